regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Write-back arbiter and sequencer for the single write port of the 32x32 `registers` file. It accepts write requests from several producers (ALU result, memory load, syscall/host) over valid/ready handshakes and grants one per cycle, round-robin. It drives the granted write into a registered output stage that feeds `writeRegister`/`rr`/`write`. It also reports read-after-write hits against the in-flight write so the decode stage can forward or stall.

## Interface
Parameters:
- NREQ, 3, number of requesters; index 0 = ALU, 1 = load, 2 = syscall/host
- AW, 5, register index width
- DW, 32, data width

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester write request
- req_ready  out  NREQ  per-requester grant; handshake completes when valid & ready at a rising edge
- req_addr  in  NREQ*AW  destination register, requester i at bits [i*AW +: AW]
- req_data  in  NREQ*DW  write data, requester i at bits [i*DW +: DW]
- hold  in  1  freeze arbitration (e.g. pipeline stall); no grants while high
- writeRegister  out  AW  to register file write index
- rr  out  DW  to register file write data
- write  out  1  to register file write enable
- grant_id  out  2  index of the requester whose write is in the output stage
- rd1, rd2  in  AW  read indices being decoded
- fwd1_hit, fwd2_hit  out  1  in-flight write targets rd1 / rd2

## Operation
- Arbitration is combinational from req_valid, hold and the round-robin pointer `last`.
  - Search order starts at (last+1) mod NREQ and wraps.
  - The first valid requester gets req_ready=1. All others are 0.
  - At most one req_ready is high in any cycle.
- If hold=1, or no requester is valid, all req_ready are 0.
- On an accepted handshake:
  - `last` is set to the granted index. It is unchanged when there is no grant.
  - The output stage captures addr, data and index.
  - write=1 for the next cycle.
- With no handshake in a cycle, write=0 next cycle. writeRegister, rr and grant_id hold their last values.
- A request to register 0 is accepted (req_ready high, handshake completes and `last` advances), but write stays 0 for that slot. $zero is never written.
- Requesters hold valid, addr and data stable until the handshake. The block does not latch un-granted requests.
- fwd1_hit = write & (writeRegister == rd1) & (rd1 != 0). fwd2_hit is the same against rd2. Both are combinational from the output stage.
- Fairness: with all NREQ requesters continuously valid, each is granted exactly once in every NREQ consecutive cycles.

## Timing
- Reset (asynchronous assert, synchronous release):
  - write=0, writeRegister=0, rr=0, grant_id=0.
  - `last`=NREQ-1, so requester 0 has first priority after reset.
  - req_ready=0 while reset_n=0.
- Latency: handshake at edge N gives write=1 with its addr/data during cycle N+1, committed by the register file in that cycle. Throughput is one write per cycle.
- Reset asserted mid-operation: any in-flight output-stage write is discarded (write drops to 0 immediately). Requests presented during reset are not accepted.
- hold rising: no grant on that edge. The output stage still retires its pending write (write=1 for one cycle), then write=0.
- hold falling: arbitration resumes from the unchanged `last`.
- Simultaneous events:
  - A new grant on the same edge the previous write retires is normal back-to-back operation; the output stage is overwritten.
  - Two requesters targeting the same register in consecutive grants are written in grant order; the second value wins.
- grant_id width is fixed at 2 and supports NREQ ≤ 4.

## Test plan
- Reset release with req_valid=3'b111 -> grants in order 0,1,2,0,…; write=1 every cycle from the cycle after the first handshake; writeRegister/rr track each requester's addr/data one cycle late.
- Only requester 1 valid (addr=5'd8, data=32'hDEADBEEF) -> req_ready=3'b010 same cycle; next cycle write=1, writeRegister=8, rr=32'hDEADBEEF, grant_id=1; fwd1_hit=1 when rd1=8.
- Requester 0 valid with addr=0, data=32'h1234 -> handshake completes; next cycle write=0, fwd hits 0 even with rd1=0; `last`=0, so next priority goes to requester 1.
- hold=1 for 3 cycles with all valid -> req_ready=0 throughout; the pending write retires once, then write=0; after release the next grant is (last+1) mod 3.
- reset_n pulsed low while write=1 -> write, writeRegister, rr drop to 0 asynchronously; after release the first grant goes to requester 0.
- Requesters 0 and 2 write reg 9 on consecutive grants (32'hA, then 32'hB) -> two write pulses, the second with rr=32'hB; a register file read of 9 afterwards returns 32'hB.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the register file's single write port.
// Registers the granted write and flags read-after-write hits for decode forwarding.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic                 hold,
    output logic [AW-1:0]        writeRegister,
    output logic [DW-1:0]        rr,
    output logic                 write,
    output logic [1:0]           grant_id,
    input  logic [AW-1:0]        rd1,
    input  logic [AW-1:0]        rd2,
    output logic                 fwd1_hit,
    output logic                 fwd2_hit
);

    localparam logic [2:0] NREQ_W     = 3'(NREQ);
    localparam logic [1:0] LAST_RESET = 2'(NREQ - 1);

    logic [1:0]    last;
    logic [1:0]    grant_idx;
    logic          grant;
    logic [2:0]    cand;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    // Search starts just after the previous winner and wraps, so the first hit is the fair choice.
    always_comb begin
        req_ready = '0;
        grant_idx = last;
        grant     = 1'b0;
        cand      = '0;
        if (reset_n && !hold) begin
            for (int off = 1; off <= NREQ; off++) begin
                cand = {1'b0, last} + 3'(off);
                if (cand >= NREQ_W) begin
                    cand = cand - NREQ_W;
                end
                if (!grant && req_valid[cand[1:0]]) begin
                    grant                 = 1'b1;
                    grant_idx             = cand[1:0];
                    req_ready[cand[1:0]]  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_addr = req_addr[grant_idx*AW +: AW];
        sel_data = req_data[grant_idx*DW +: DW];
    end

    // A grant to $zero still completes the handshake and advances `last`, but never raises write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last          <= LAST_RESET;
            writeRegister <= '0;
            rr            <= '0;
            write         <= 1'b0;
            grant_id      <= '0;
        end else if (grant) begin
            last          <= grant_idx;
            writeRegister <= sel_addr;
            rr            <= sel_data;
            grant_id      <= grant_idx;
            write         <= (sel_addr != '0);
        end else begin
            write         <= 1'b0;
        end
    end

    assign fwd1_hit = write && (writeRegister == rd1) && (rd1 != '0);
    assign fwd2_hit = write && (writeRegister == rd2) && (rd2 != '0);

endmodule
